hanoi_sequencer: RTL and testbench

HANOI_SEQUENCER -- requirements
Module: hanoi_sequencer

---
 rtl/hanoi_pkg.sv | 29 ++
 rtl/hanoi_mod3.sv | 19 +
 rtl/hanoi_sequencer.sv | 140 ++++++++++++++
 tb/tb_hanoi_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hanoi_pkg.sv
// Shared types, peg constants and small helpers for the Tower of Hanoi move sequencer.
package hanoi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] PEG0     = 2'd0;
  localparam logic [1:0] PEG1     = 2'd1;
  localparam logic [1:0] PEG2     = 2'd2;
  localparam logic [1:0] PEG_NONE = 2'd0;

  // Adds two residues (0..2) and folds the sum back into 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) return 2'(s - 3'd3);
    return s[1:0];
  endfunction

  function automatic logic [1:0] peg_swap(input logic [1:0] p, input logic en);
    if (en && p == PEG1) return PEG2;
    if (en && p == PEG2) return PEG1;
    return p;
  endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational residue modulo 3 of a W-bit unsigned value.
module hanoi_mod3
  import hanoi_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] val,
  output logic [1:0]   res
);

  // 2^i mod 3 alternates 1,2,1,2,... so each set bit adds its weight.
  always_comb begin
    res = 2'd0;
    for (int i = 0; i < W; i++) begin
      if (val[i]) res = mod3_add(res, (i % 2 == 0) ? 2'd1 : 2'd2);
    end
  end

endmodule

// File: rtl/hanoi_sequencer.sv
// Iterative Tower of Hanoi move generator with a valid/ready move handshake,
// move counting and per-peg disk occupancy tracking.
module hanoi_sequencer
  import hanoi_pkg::*;
#(
  parameter  int S  = 4,
  parameter  int MW = S,
  localparam int CW = $clog2(S + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    tgt,
  input  logic          abort,
  input  logic          mv_ready,
  output logic          mv_valid,
  output logic [1:0]    fr,
  output logic [1:0]    to,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [MW-1:0] move_cnt,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2
);

  localparam int            AW         = MW + 2;
  localparam logic [AW-1:0] LAST_M     = AW'((1 << S) - 1);
  localparam logic [1:0]    NATIVE_PEG = (S % 2 == 1) ? PEG2 : PEG1;

  state_t        state;
  logic [AW-1:0] m;
  logic [AW-1:0] m_next;
  logic [MW:0]   fr_arg;
  logic [MW:0]   to_arg;
  logic [1:0]    raw_fr;
  logic [1:0]    raw_to;
  logic [1:0]    nxt_fr;
  logic [1:0]    nxt_to;
  logic [1:0]    tgt_q;
  logic [1:0]    sel_tgt;
  logic          hs;
  logic          swap;

  function automatic logic [CW-1:0] peg_cnt(input logic [CW-1:0] c, input logic [1:0] p,
                                            input logic [1:0] f, input logic [1:0] t);
    if (t == p) return c + CW'(1);
    if (f == p) return c - CW'(1);
    return c;
  endfunction

  assign hs = mv_valid & mv_ready;

  // Index of the move to present next; fr/to are registered from it.
  always_comb begin
    m_next = m;
    if (state == IDLE) m_next = AW'(1);
    else if (hs)       m_next = m + AW'(1);
  end

  assign fr_arg = (MW + 1)'(m_next & (m_next - AW'(1)));
  assign to_arg = (MW + 1)'((m_next | (m_next - AW'(1))) + AW'(1));

  hanoi_mod3 #(.W(MW + 1)) u_mod_fr (.val(fr_arg), .res(raw_fr));
  hanoi_mod3 #(.W(MW + 1)) u_mod_to (.val(to_arg), .res(raw_to));

  // The raw sequence ends on NATIVE_PEG; mirror pegs 1/2 when the target is the other one.
  assign sel_tgt = (state == IDLE) ? tgt : tgt_q;
  assign swap    = (sel_tgt != NATIVE_PEG);
  assign nxt_fr  = peg_swap(raw_fr, swap);
  assign nxt_to  = peg_swap(raw_to, swap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      m        <= AW'(1);
      tgt_q    <= PEG1;
      mv_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fr       <= PEG_NONE;
      to       <= PEG_NONE;
      move_cnt <= '0;
      cnt0     <= CW'(S);
      cnt1     <= '0;
      cnt2     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (tgt == PEG1 || tgt == PEG2) begin
              state    <= RUN;
              m        <= m_next;
              tgt_q    <= tgt;
              move_cnt <= '0;
              cnt0     <= CW'(S);
              cnt1     <= '0;
              cnt2     <= '0;
              mv_valid <= 1'b1;
              busy     <= 1'b1;
              fr       <= nxt_fr;
              to       <= nxt_to;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            move_cnt <= move_cnt + MW'(1);
            cnt0     <= peg_cnt(cnt0, PEG0, fr, to);
            cnt1     <= peg_cnt(cnt1, PEG1, fr, to);
            cnt2     <= peg_cnt(cnt2, PEG2, fr, to);
          end
          // A move accepted alongside abort still counts; the run then ends without done.
          if (abort || (hs && m == LAST_M)) begin
            state    <= abort ? IDLE : FIN;
            done     <= ~abort;
            mv_valid <= 1'b0;
            busy     <= 1'b0;
            fr       <= PEG_NONE;
            to       <= PEG_NONE;
          end else begin
            m  <= m_next;
            fr <= nxt_fr;
            to <= nxt_to;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hanoi_sequencer.sv
// Directed checks of hanoi_sequencer with S=2, S=3 and S=4 instances sharing clock and reset.
module tb_hanoi_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       st2, ab2, rd2, mv2, busy2, done2, err2;
  logic [1:0] tg2, fr2, to2, mc2, c20, c21, c22;

  logic       st3, ab3, rd3, mv3, busy3, done3, err3;
  logic [1:0] tg3, fr3, to3, c30, c31, c32;
  logic [2:0] mc3;

  logic       st4, ab4, rd4, mv4, busy4, done4, err4;
  logic [1:0] tg4, fr4, to4;
  logic [3:0] mc4;
  logic [2:0] c40, c41, c42;

  logic [1:0] tfr3 [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [1:0] tto3 [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};

  hanoi_sequencer #(.S(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .tgt(tg2), .abort(ab2), .mv_ready(rd2),
    .mv_valid(mv2), .fr(fr2), .to(to2), .busy(busy2), .done(done2), .err(err2),
    .move_cnt(mc2), .cnt0(c20), .cnt1(c21), .cnt2(c22)
  );

  hanoi_sequencer #(.S(3)) u3 (
    .clk(clk), .rst(rst), .start(st3), .tgt(tg3), .abort(ab3), .mv_ready(rd3),
    .mv_valid(mv3), .fr(fr3), .to(to3), .busy(busy3), .done(done3), .err(err3),
    .move_cnt(mc3), .cnt0(c30), .cnt1(c31), .cnt2(c32)
  );

  hanoi_sequencer #(.S(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .tgt(tg4), .abort(ab4), .mv_ready(rd4),
    .mv_valid(mv4), .fr(fr4), .to(to4), .busy(busy4), .done(done4), .err(err4),
    .move_cnt(mc4), .cnt0(c40), .cnt1(c41), .cnt2(c42)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_move2(input string tag, input logic [1:0] efr, input logic [1:0] eto);
    check_output({tag, "_valid"}, mv2, 1);
    check_output({tag, "_fr"}, fr2, efr);
    check_output({tag, "_to"}, to2, eto);
  endtask

  initial begin
    int k;
    int dones;
    rst = 1'b0;
    st2 = 0; tg2 = 0; ab2 = 0; rd2 = 0;
    st3 = 0; tg3 = 0; ab3 = 0; rd3 = 0;
    st4 = 0; tg4 = 0; ab4 = 0; rd4 = 0;

    #12;
    check_output("rst_valid", mv4, 0);
    check_output("rst_busy", busy4, 0);
    check_output("rst_fr", fr4, 0);
    check_output("rst_mc", mc4, 0);
    check_output("rst_cnt0_s4", c40, 4);
    check_output("rst_cnt0_s2", c20, 2);
    check_output("rst_cnt1_s4", c41, 0);
    tick();
    rst = 1'b1;

    // S=2, target peg 1: native ordering
    st2 = 1; tg2 = 1; rd2 = 1;
    tick();
    st2 = 0;
    check_output("a_busy", busy2, 1);
    check_move2("a_m1", 0, 2);
    tick();
    check_move2("a_m2", 0, 1);
    tick();
    check_move2("a_m3", 2, 1);
    tick();
    check_output("a_done", done2, 1);
    check_output("a_valid_fin", mv2, 0);
    check_output("a_fr_fin", fr2, 0);
    check_output("a_mc", mc2, 3);
    check_output("a_cnt0", c20, 0);
    check_output("a_cnt1", c21, 2);
    check_output("a_cnt2", c22, 0);
    check_output("a_err", err2, 0);
    tick();
    check_output("a_done_off", done2, 0);
    check_output("a_busy_off", busy2, 0);

    // S=2, target peg 2: pegs 1/2 mirrored
    st2 = 1; tg2 = 2;
    tick();
    st2 = 0;
    check_move2("b_m1", 0, 1);
    tick();
    check_move2("b_m2", 0, 2);
    tick();
    check_move2("b_m3", 1, 2);
    tick();
    check_output("b_done", done2, 1);
    check_output("b_cnt2", c22, 2);
    check_output("b_cnt1", c21, 0);
    check_output("b_mc", mc2, 3);

    // S=3, target peg 2, ready toggled randomly
    st3 = 1; tg3 = 2;
    tick();
    st3 = 0;
    k = 0;
    dones = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done3) dones++;
      if (dones > 0) break;
      if (mv3) begin
        if (k < 7) begin
          check_output("c_fr", fr3, tfr3[k]);
          check_output("c_to", to3, tto3[k]);
        end else begin
          check_output("c_extra_valid", mv3, 0);
        end
      end
      rd3 = (cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mv3 && rd3) k++;
      tick();
    end
    rd3 = 0;
    check_output("c_done_seen", dones, 1);
    check_output("c_handshakes", k, 7);
    check_output("c_mc", mc3, 7);
    check_output("c_cnt2", c32, 3);
    check_output("c_cnt0", c30, 0);
    check_output("c_cnt1", c31, 0);
    tick();
    check_output("c_done_once", done3, 0);
    check_output("c_busy", busy3, 0);
    check_output("c_err", err3, 0);

    // Rejected targets
    st4 = 1; tg4 = 0;
    tick();
    st4 = 0;
    check_output("d0_err", err4, 1);
    check_output("d0_busy", busy4, 0);
    check_output("d0_valid", mv4, 0);
    tick();
    check_output("d0_err_off", err4, 0);
    check_output("d0_cnt0", c40, 4);
    st4 = 1; tg4 = 3;
    tick();
    st4 = 0;
    check_output("d3_err", err4, 1);
    check_output("d3_busy", busy4, 0);
    tick();
    check_output("d3_err_off", err4, 0);
    check_output("d3_cnt0", c40, 4);
    check_output("d3_mc", mc4, 0);

    // S=4 abort after five handshakes
    st4 = 1; tg4 = 1; rd4 = 1;
    tick();
    st4 = 0;
    check_output("e_m1_fr", fr4, 0);
    check_output("e_m1_to", to4, 2);
    repeat (4) tick();
    check_output("e_m5_fr", fr4, 1);
    check_output("e_m5_to", to4, 0);
    tick();
    rd4 = 0; ab4 = 1;
    tick();
    ab4 = 0;
    check_output("e_busy", busy4, 0);
    check_output("e_valid", mv4, 0);
    check_output("e_done", done4, 0);
    check_output("e_mc", mc4, 5);
    check_output("e_cnt0", c40, 2);
    check_output("e_cnt1", c41, 1);
    check_output("e_cnt2", c42, 1);
    tick();
    check_output("e_done_later", done4, 0);
    check_output("e_valid_later", mv4, 0);
    st4 = 1; tg4 = 1;
    tick();
    st4 = 0;
    check_output("e_restart_cnt0", c40, 4);
    check_output("e_restart_mc", mc4, 0);
    check_output("e_restart_valid", mv4, 1);

    // Abort coinciding with a handshake: move counted, then idle
    rd4 = 1; ab4 = 1;
    tick();
    rd4 = 0; ab4 = 0;
    check_output("f_mc", mc4, 1);
    check_output("f_cnt0", c40, 3);
    check_output("f_cnt2", c42, 1);
    check_output("f_busy", busy4, 0);
    check_output("f_valid", mv4, 0);

    // Asynchronous reset in the middle of a run
    st4 = 1; tg4 = 2; rd4 = 1;
    tick();
    st4 = 0;
    tick();
    tick();
    check_output("g_mc_pre", mc4, 2);
    #2 rst = 1'b0;
    #1;
    check_output("g_valid", mv4, 0);
    check_output("g_busy", busy4, 0);
    check_output("g_mc", mc4, 0);
    check_output("g_cnt0", c40, 4);
    check_output("g_fr", fr4, 0);
    check_output("g_to", to4, 0);
    tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      check_output("g_valid_after", mv4, 0);
    end
    check_output("g_busy_after", busy4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
